cfg_link_sched: RTL
===================

CFG_LINK_SCHED -- requirements
Module: cfg_link_sched

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8: CLK cycles per serial bit period; even, at least 2.
REQ-002 SHALL have parameter GAP_BITS, default 4: idle bit periods inserted before each frame.
REQ-003 SHALL have parameter REFRESH_CYCLES, default 1000000: CLK cycles from load completion to auto-refresh request.
REQ-004 SHALL use one clock; reset is asynchronous and active-low. Ports follow.
REQ-005 CLK  in  1  block clock; all logic on rising edge.
REQ-006 RST_N  in  1  asynchronous active-low reset.
REQ-007 req_a / req_b  in  1  load request from requester A / B; held until ack.
REQ-008 dyn_a / dyn_b  in  16  DYNCNF word.
REQ-009 stat_a / stat_b  in  88  STATCNF word.
REQ-010 stat_en_a / stat_en_b  in  1  send STATCNF after DYNCNF.
REQ-011 ack_a / ack_b  out  1  one-cycle completion pulse.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 grant_id  out  2  00 none, 01 A, 10 B, 11 refresh.
REQ-014 SCLK / SEL / MOSI  out  1  serial link to the analog configuration registers.

Function
REQ-015 States SHALL be IDLE, GAP, DYN, STAT and DONE.
REQ-016 IDLE: a sampled request SHALL capture that requester's dyn, stat and stat_en into shadow registers, set grant_id, and enter GAP on the next cycle.
REQ-017 Arbitration SHALL be round-robin when req_a and req_b are both high: grant goes to the requester not granted last; after reset, A wins.
REQ-018 GAP SHALL last GAP_BITS*CLK_DIV cycles, then enter DYN.
REQ-019 DYN SHALL shift 16 bits MSB first, one per CLK_DIV cycles, with SEL=1; exit to STAT if stat_en was captured, else DONE.
REQ-020 STAT SHALL shift 88 bits MSB first with SEL=0, then enter DONE.
REQ-021 MOSI SHALL change only at divider count 0. SCLK=1 for counts CLK_DIV/2..CLK_DIV-1, else 0. SCLK=0 and MOSI=0 outside DYN/STAT.
REQ-022 DONE SHALL last one cycle. It pulses the granted ack, returns to IDLE and clears grant_id.
REQ-023 The requester drops req in the cycle it sees ack; any req high in IDLE afterwards is a new request.
REQ-024 req or data changes after grant SHALL NOT affect the frame in progress; req deasserted before grant is not serviced.
REQ-025 Divider and bit counters SHALL reset to 0 on every state entry; no wrap into a following state.

Reset
REQ-026 RST_N low SHALL immediately force: state IDLE, SCLK=SEL=MOSI=0, ack_a=ack_b=0, busy=0, grant_id=00, shadows and counters 0, round-robin pointer to A, refresh pending cleared.
REQ-027 Reset mid-frame SHALL abort without an ack; a requester must re-request after release.

Configuration
REQ-028 Macro CFG_LINK_REFRESH_EN SHALL compile in auto-refresh. The timer starts at each DONE and counts REFRESH_CYCLES. On expiry it sets a pending flag. In IDLE the pending flag replays the last shadow contents with grant_id=11, no ack. External requests take priority; pending persists until served. Timer is inactive before the first load.
REQ-029 Without CFG_LINK_REFRESH_EN there SHALL be no timer or pending logic, and grant_id SHALL never be 11.

Structure
REQ-030 Shared package asic_cfg_pkg SHALL hold the state enum, grant_id codes, DYN_W=16 and STAT_W=88.
REQ-031 Sub-module cfg_bit_timer SHALL provide the CLK_DIV divider, bit-period tick and bit counter.

Verification
REQ-032 Defaults; req_a with dyn_a=16'hABC6, stat_en_a=0, sampled at t0 -> GAP t0+1..t0+32; SEL=1 t0+33..t0+160; MOSI bits 1010101111000110; ack_a at t0+161.
REQ-033 Same plus stat_en_a=1, stat_a=88'h123456789ABCDEF1234567 -> 88 STAT bits MSB first with SEL=0; ack_a at t0+865.
REQ-034 req_a and req_b high together from reset -> A served first, then B; grant_id 01 then 10; one ack each.
REQ-035 RST_N low at t0+100 of a frame -> all outputs 0 immediately; no ack; a new req_a after release is served normally.
REQ-036 With CFG_LINK_REFRESH_EN and REFRESH_CYCLES=1000 -> replay of last frame with grant_id=11, 1000 cycles after DONE. req_b at the same expiry -> B first, then refresh.

Source files
------------

// File: rtl/asic_cfg_pkg.sv
// asic_cfg_pkg: state encoding, grant codes and word widths shared by the
// configuration link scheduler and its bit timer.
package asic_cfg_pkg;

    localparam int DYN_W  = 16;
    localparam int STAT_W = 88;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_DYN  = 3'd2,
        ST_STAT = 3'd3,
        ST_DONE = 3'd4
    } link_state_t;

    localparam logic [1:0] GID_NONE = 2'b00;
    localparam logic [1:0] GID_A    = 2'b01;
    localparam logic [1:0] GID_B    = 2'b10;
    localparam logic [1:0] GID_REF  = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cfg_bit_timer.sv
// cfg_bit_timer: CLK_DIV clock divider with a bit-period tick and a count of
// completed bit periods. Both counters return to 0 on clr so every state
// starts from a clean bit boundary.
module cfg_bit_timer #(
    parameter int CLK_DIV = 8,
    parameter int DIV_W   = 3,
    parameter int CNT_W   = 7
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clr,
    input  logic             en,
    output logic [DIV_W-1:0] div_cnt,
    output logic             tick,
    output logic [CNT_W-1:0] bit_cnt
);

    assign tick = en && (div_cnt == DIV_W'(CLK_DIV - 1));

    // Divider and bit counter; tick marks the last clock of a bit period.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (en) begin
            if (tick) begin
                div_cnt <= '0;
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfg_link_sched.sv
// cfg_link_sched: arbitrates two configuration requesters and serialises the
// granted DYNCNF word (SEL=1) and optional STATCNF word (SEL=0) onto the
// analog configuration link.
// Build option: define CFG_LINK_REFRESH_EN to compile in periodic replay of
// the last loaded frame (grant_id=11, no ack).
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting; a request (or pending refresh) is captured here
// GAP     | GAP_BITS idle bit periods before the frame
// DYN     | shift 16-bit DYNCNF MSB first, SEL=1
// STAT    | shift 88-bit STATCNF MSB first, SEL=0 (only if stat_en)
// DONE    | one cycle: ack to the granted requester, grant cleared
import asic_cfg_pkg::*;

module cfg_link_sched #(
    parameter int CLK_DIV        = 8,
    parameter int GAP_BITS       = 4,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [DYN_W-1:0]  dyn_a,
    input  logic [DYN_W-1:0]  dyn_b,
    input  logic [STAT_W-1:0] stat_a,
    input  logic [STAT_W-1:0] stat_b,
    input  logic              stat_en_a,
    input  logic              stat_en_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic              busy,
    output logic [1:0]        grant_id,
    output logic              SCLK,
    output logic              SEL,
    output logic              MOSI
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(max_int(GAP_BITS, STAT_W) + 1);
    localparam int HALF  = CLK_DIV / 2;

    link_state_t        state_q;
    link_state_t        state_d;
    logic               clr;
    logic               en;
    logic               tick;
    logic [DIV_W-1:0]   div_cnt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DYN_W-1:0]   dyn_sh;
    logic [STAT_W-1:0]  stat_sh;
    logic               stat_en_sh;
    logic [1:0]         grant_q;
    logic               rr_b;
    logic [STAT_W-1:0]  sreg;
    logic               pick_a;
    logic               pick_b;
    logic               pick_ref;
    logic               refresh_req;
    logic               shifting;
    logic               gap_last;
    logic               dyn_last;
    logic               stat_last;

    cfg_bit_timer #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W),
        .CNT_W   (CNT_W)
    ) u_bit_timer (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .clr     (clr),
        .en      (en),
        .div_cnt (div_cnt),
        .tick    (tick),
        .bit_cnt (bit_cnt)
    );

    // rr_b=1 means B has priority on a tie (A was granted last).
    assign pick_a   = req_a && (!req_b || !rr_b);
    assign pick_b   = req_b && !pick_a;
    assign pick_ref = refresh_req && !req_a && !req_b;

    assign shifting  = (state_q == ST_DYN) || (state_q == ST_STAT);
    assign en        = shifting || (state_q == ST_GAP);
    assign gap_last  = tick && (bit_cnt == CNT_W'(GAP_BITS - 1));
    assign dyn_last  = tick && (bit_cnt == CNT_W'(DYN_W - 1));
    assign stat_last = tick && (bit_cnt == CNT_W'(STAT_W - 1));
    assign clr       = (state_d != state_q);
    assign grant_id  = grant_q;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and link/handshake outputs.
    always_comb begin
        state_d = state_q;
        ack_a   = 1'b0;
        ack_b   = 1'b0;
        SEL     = 1'b0;
        SCLK    = 1'b0;
        MOSI    = 1'b0;
        busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (pick_a || pick_b || pick_ref) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_last) begin
                    state_d = ST_DYN;
                end
            end
            ST_DYN: begin
                SEL = 1'b1;
                if (dyn_last) begin
                    state_d = stat_en_sh ? ST_STAT : ST_DONE;
                end
            end
            ST_STAT: begin
                if (stat_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ack_a   = (grant_q == GID_A);
                ack_b   = (grant_q == GID_B);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (shifting) begin
            SCLK = (div_cnt >= DIV_W'(HALF));
            MOSI = sreg[STAT_W-1];
        end
    end

    // Shadow capture at grant, arbitration pointer and frame shift register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dyn_sh     <= '0;
            stat_sh    <= '0;
            stat_en_sh <= 1'b0;
            grant_q    <= GID_NONE;
            rr_b       <= 1'b0;
            sreg       <= '0;
        end else begin
            if (state_q == ST_IDLE) begin
                if (pick_a) begin
                    dyn_sh     <= dyn_a;
                    stat_sh    <= stat_a;
                    stat_en_sh <= stat_en_a;
                    grant_q    <= GID_A;
                    rr_b       <= 1'b1;
                end else if (pick_b) begin
                    dyn_sh     <= dyn_b;
                    stat_sh    <= stat_b;
                    stat_en_sh <= stat_en_b;
                    grant_q    <= GID_B;
                    rr_b       <= 1'b0;
                end else if (pick_ref) begin
                    // Refresh replays the shadows untouched.
                    grant_q <= GID_REF;
                end
            end
            if (state_q == ST_DONE) begin
                grant_q <= GID_NONE;
            end
            // The DYNCNF word is left-aligned so both words leave from the MSB.
            if ((state_q == ST_GAP) && gap_last) begin
                sreg <= {dyn_sh, {(STAT_W - DYN_W){1'b0}}};
            end else if ((state_q == ST_DYN) && dyn_last && stat_en_sh) begin
                sreg <= stat_sh;
            end else if (shifting && tick) begin
                sreg <= {sreg[STAT_W-2:0], 1'b0};
            end
        end
    end

`ifdef CFG_LINK_REFRESH_EN
    localparam int RW = $clog2(REFRESH_CYCLES + 1);

    logic [RW-1:0] ref_cnt;
    logic          ref_run;
    logic          ref_pend;
    logic          ref_exp;

    // Expiry is visible in the cycle the count reaches zero so an idle
    // scheduler replays exactly REFRESH_CYCLES after DONE.
    assign ref_exp     = ref_run && (ref_cnt == '0);
    assign refresh_req = ref_pend || ref_exp;

    // Down-counting refresh timer, restarted at every DONE; pending survives
    // any number of external frames until IDLE serves it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ref_cnt  <= '0;
            ref_run  <= 1'b0;
            ref_pend <= 1'b0;
        end else begin
            if (state_q == ST_DONE) begin
                ref_cnt <= RW'(REFRESH_CYCLES - 1);
                ref_run <= 1'b1;
            end else if (ref_run) begin
                if (ref_cnt == '0) begin
                    ref_run <= 1'b0;
                end else begin
                    ref_cnt <= ref_cnt - 1'b1;
                end
            end
            if (ref_exp) begin
                ref_pend <= 1'b1;
            end
            if ((state_q == ST_IDLE) && pick_ref) begin
                ref_pend <= 1'b0;
            end
        end
    end
`else
    // Refresh compiled out. REFRESH_CYCLES is referenced only so the
    // parameter list matches across builds; a legal value is never negative.
    assign refresh_req = (REFRESH_CYCLES < 0);
`endif

endmodule
